// File: rtl/psevdo_ram_arbiter.sv
// psevdo_ram_arbiter: serialises two requesters onto one psevdo_ram_block.
// Build option PSEVDO_RAM_ARB_FIXED_PRIO_EN: A always wins contention.
module psevdo_ram_arbiter (
  input  logic       CLKS,
  input  logic       RSTB,
  input  logic       REQA,
  input  logic       REQB,
  input  logic       WEA,
  input  logic       WEB,
  input  logic [1:0] BANKA,
  input  logic [1:0] BANKB,
  input  logic [7:0] ADDRA,
  input  logic [7:0] ADDRB,
  input  logic [8:0] WDATAA,
  input  logic [8:0] WDATAB,
  output logic       ACKA,
  output logic       ACKB,
  output logic [8:0] RDATAA,
  output logic [8:0] RDATAB,
  output logic [8:0] RAM_DIN,
  output logic [7:0] RAM_WADDR,
  output logic [7:0] RAM_RADDR,
  output logic       RAM_WRB,
  output logic       RAM_RDB,
  output logic [2:0] RAM_DC,
  input  logic [8:0] RAM_DO1,
  input  logic [8:0] RAM_DO2
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_CAP  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e     state_q;
  logic       owner_q;
  logic [1:0] bank_q;
  logic [7:0] addr_q;
  logic [8:0] wdata_q;
  logic       wrb_q;
  logic       rdb_q;
  logic       acka_q;
  logic       ackb_q;
  logic [8:0] rdata_a_q;
  logic [8:0] rdata_b_q;

`ifndef PSEVDO_RAM_ARB_FIXED_PRIO_EN
  logic       last_q;
`endif

  logic       gnt_v_d;
  logic       gnt_b_d;
  logic       gnt_we_d;
  logic [1:0] gnt_bank_d;
  logic [7:0] gnt_addr_d;
  logic [8:0] gnt_wdata_d;
  logic [8:0] cap_word;

  // Pick the winner and mux its request fields.
  always_comb begin
    gnt_v_d = REQA | REQB;
`ifdef PSEVDO_RAM_ARB_FIXED_PRIO_EN
    gnt_b_d = REQB & ~REQA;
`else
    gnt_b_d = (REQA & REQB) ? ~last_q : REQB;
`endif
    gnt_we_d    = gnt_b_d ? WEB    : WEA;
    gnt_bank_d  = gnt_b_d ? BANKB  : BANKA;
    gnt_addr_d  = gnt_b_d ? ADDRB  : ADDRA;
    gnt_wdata_d = gnt_b_d ? WDATAB : WDATAA;
  end

  // Banks 0/1 drive DO1, banks 2/3 drive DO2.
  assign cap_word = bank_q[1] ? RAM_DO2 : RAM_DO1;

  // Access sequencer with registered strobes, acks and read data.
  always_ff @(posedge CLKS or negedge RSTB) begin
    if (!RSTB) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      bank_q    <= 2'd0;
      addr_q    <= 8'd0;
      wdata_q   <= 9'd0;
      wrb_q     <= 1'b1;
      rdb_q     <= 1'b1;
      acka_q    <= 1'b0;
      ackb_q    <= 1'b0;
      rdata_a_q <= 9'd0;
      rdata_b_q <= 9'd0;
`ifndef PSEVDO_RAM_ARB_FIXED_PRIO_EN
      last_q    <= 1'b1;
`endif
    end else begin
      acka_q <= 1'b0;
      ackb_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (gnt_v_d) begin
            owner_q <= gnt_b_d;
            bank_q  <= gnt_bank_d;
            addr_q  <= gnt_addr_d;
            wdata_q <= gnt_wdata_d;
`ifndef PSEVDO_RAM_ARB_FIXED_PRIO_EN
            last_q  <= gnt_b_d;
`endif
            if (gnt_we_d) begin
              wrb_q   <= 1'b0;
              state_q <= S_WR;
            end else begin
              rdb_q   <= 1'b0;
              state_q <= S_RD;
            end
          end
        end
        S_WR: begin
          wrb_q   <= 1'b1;
          state_q <= S_DONE;
        end
        S_RD: begin
          rdb_q   <= 1'b1;
          state_q <= S_CAP;
        end
        S_CAP: begin
          if (owner_q) rdata_b_q <= cap_word;
          else         rdata_a_q <= cap_word;
          state_q <= S_DONE;
        end
        S_DONE: begin
          acka_q  <= ~owner_q;
          ackb_q  <= owner_q;
          state_q <= S_IDLE;
        end
        default: begin
          wrb_q   <= 1'b1;
          rdb_q   <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ACKA      = acka_q;
  assign ACKB      = ackb_q;
  assign RDATAA    = rdata_a_q;
  assign RDATAB    = rdata_b_q;
  assign RAM_DIN   = wdata_q;
  assign RAM_WADDR = addr_q;
  assign RAM_RADDR = addr_q;
  assign RAM_WRB   = wrb_q;
  assign RAM_RDB   = rdb_q;
  assign RAM_DC    = {1'b0, bank_q};

endmodule

// File: tb/tb_psevdo_ram_arbiter.sv
// tb_psevdo_ram_arbiter: directed and random traffic against a
// transaction-timeline model of the arbiter plus a simple RAM model.
module tb_psevdo_ram_arbiter;

  logic       CLKS = 1'b0;
  logic       RSTB = 1'b0;
  logic       REQA = 1'b0, REQB = 1'b0;
  logic       WEA = 1'b0, WEB = 1'b0;
  logic [1:0] BANKA = 2'd0, BANKB = 2'd0;
  logic [7:0] ADDRA = 8'd0, ADDRB = 8'd0;
  logic [8:0] WDATAA = 9'd0, WDATAB = 9'd0;
  logic       ACKA, ACKB;
  logic [8:0] RDATAA, RDATAB;
  logic [8:0] RAM_DIN;
  logic [7:0] RAM_WADDR, RAM_RADDR;
  logic       RAM_WRB, RAM_RDB;
  logic [2:0] RAM_DC;
  logic [8:0] RAM_DO1 = 9'd0, RAM_DO2 = 9'd0;

  int n_tests = 0;
  int n_fail  = 0;

  psevdo_ram_arbiter dut (
    .CLKS(CLKS), .RSTB(RSTB),
    .REQA(REQA), .REQB(REQB),
    .WEA(WEA), .WEB(WEB),
    .BANKA(BANKA), .BANKB(BANKB),
    .ADDRA(ADDRA), .ADDRB(ADDRB),
    .WDATAA(WDATAA), .WDATAB(WDATAB),
    .ACKA(ACKA), .ACKB(ACKB),
    .RDATAA(RDATAA), .RDATAB(RDATAB),
    .RAM_DIN(RAM_DIN), .RAM_WADDR(RAM_WADDR), .RAM_RADDR(RAM_RADDR),
    .RAM_WRB(RAM_WRB), .RAM_RDB(RAM_RDB), .RAM_DC(RAM_DC),
    .RAM_DO1(RAM_DO1), .RAM_DO2(RAM_DO2)
  );

  always #5 CLKS = ~CLKS;

  // RAM block: write at the edge closing a WRB-low cycle, read registered.
  logic [8:0] mem [4][256];
  initial
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 256; a++)
        mem[b][a] = 9'd0;

  always @(posedge CLKS) begin
    if (!RAM_WRB) mem[RAM_DC[1:0]][RAM_WADDR] <= RAM_DIN;
    if (!RAM_RDB) begin
      if (RAM_DC[1]) RAM_DO2 <= mem[RAM_DC[1:0]][RAM_RADDR];
      else           RAM_DO1 <= mem[RAM_DC[1:0]][RAM_RADDR];
    end
  end

  task automatic chk(input string name, input logic [49:0] act,
                     input logic [49:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [8:0] gold [4][256];
  initial
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 256; a++)
        gold[b][a] = 9'd0;

  int         cyc = 0;
  int         g = 0;
  bit         busy = 0;
  bit         m_owner = 0;
  bit         m_we = 0;
  bit         m_last = 1;
  logic [8:0] m_rd = 9'd0;
  int         ack_cyc = -10;
  bit         ack_who = 0;
  logic [2:0] e_dc = 3'd0;
  logic [7:0] e_addr = 8'd0;
  logic [8:0] e_din = 9'd0;
  logic [8:0] e_rda = 9'd0, e_rdb = 9'd0;
  int         model_acks = 0;
  int         dut_acks = 0;

  task automatic model_reset();
    busy    = 0;
    m_last  = 1;
    ack_cyc = -10;
    e_dc    = 3'd0;
    e_addr  = 8'd0;
    e_din   = 9'd0;
    e_rda   = 9'd0;
    e_rdb   = 9'd0;
  endtask

  task automatic model_step();
    bit         own;
    logic [1:0] bk;
    logic [7:0] ad;
    cyc++;
    if (busy) begin
      if (!m_we && cyc == g + 2) begin
        if (m_owner) e_rdb = m_rd;
        else         e_rda = m_rd;
      end
      if (cyc == g + (m_we ? 2 : 3)) begin
        busy    = 0;
        ack_cyc = cyc;
        ack_who = m_owner;
        model_acks++;
      end
    end else if (REQA || REQB) begin
`ifdef PSEVDO_RAM_ARB_FIXED_PRIO_EN
      own = !REQA;
`else
      own = (REQA && REQB) ? !m_last : !REQA;
`endif
      m_last  = own;
      m_owner = own;
      m_we    = own ? WEB : WEA;
      bk      = own ? BANKB : BANKA;
      ad      = own ? ADDRB : ADDRA;
      e_din   = own ? WDATAB : WDATAA;
      e_dc    = {1'b0, bk};
      e_addr  = ad;
      if (m_we) gold[bk][ad] = e_din;
      else      m_rd = gold[bk][ad];
      g    = cyc;
      busy = 1;
    end
  endtask

  // Single compare process: model advances at each edge, outputs checked 1ns later.
  initial begin
    logic [49:0] ev, av;
    bit e_wrb, e_rdbs, e_acka, e_ackb;
    forever begin
      @(posedge CLKS or negedge RSTB);
      if (!RSTB) model_reset();
      else       model_step();
      #1;
      e_wrb  = !(busy && m_we && cyc == g);
      e_rdbs = !(busy && !m_we && cyc == g);
      e_acka = (ack_cyc == cyc) && !ack_who;
      e_ackb = (ack_cyc == cyc) && ack_who;
      ev = {e_acka, e_ackb, e_wrb, e_rdbs, e_dc, e_addr, e_addr, e_din,
            e_rda, e_rdb};
      av = {ACKA, ACKB, RAM_WRB, RAM_RDB, RAM_DC, RAM_WADDR, RAM_RADDR,
            RAM_DIN, RDATAA, RDATAB};
      chk("cycle_outputs", av, ev);
      chk("strobe_excl", 50'(!RAM_WRB && !RAM_RDB), 50'd0);
      if (ACKA === 1'b1) dut_acks++;
      if (ACKB === 1'b1) dut_acks++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_fields(input int who, input bit we, input logic [1:0] bk,
                            input logic [7:0] ad, input logic [8:0] wd);
    if (who == 0) begin
      WEA = we; BANKA = bk; ADDRA = ad; WDATAA = wd;
    end else begin
      WEB = we; BANKB = bk; ADDRB = ad; WDATAB = wd;
    end
  endtask

  task automatic set_req(input int who, input bit v);
    if (who == 0) REQA = v;
    else          REQB = v;
  endtask

  task automatic rand_fields(input int who);
    set_fields(who, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               8'($urandom_range(0, 3)), 9'($urandom_range(0, 511)));
  endtask

  // One access from the current negedge; returns negedges until ACK seen.
  task automatic access(input int who, input bit we, input logic [1:0] bk,
                        input logic [7:0] ad, input logic [8:0] wd,
                        output int lat, output logic [8:0] rd,
                        output logic [2:0] dc);
    set_fields(who, we, bk, ad, wd);
    set_req(who, 1);
    lat = 0;
    rd  = 9'd0;
    dc  = 3'd0;
    while (lat < 30) begin
      @(negedge CLKS);
      lat++;
      if ((who == 0) ? ACKA : ACKB) begin
        rd = (who == 0) ? RDATAA : RDATAB;
        dc = RAM_DC;
        break;
      end
    end
    set_req(who, 0);
  endtask

  task automatic req_loop(input int who, input int ncyc);
    bit req = 0;
    int tmo = 0;
    int n = 0;
    bit stop = 0;
    while (1) begin
      @(negedge CLKS);
      n++;
      if (n >= ncyc) stop = 1;
      if (n >= ncyc + 400) begin
        n_tests++; n_fail++;
        $display("FAIL drain_bound: requester %0d still busy", who);
        set_req(who, 0);
        break;
      end
      if (req) begin
        if ((who == 0) ? ACKA : ACKB) begin
          tmo = 0;
          if (!stop && $urandom_range(0, 1) == 1) rand_fields(who);
          else begin
            req = 0;
            set_req(who, 0);
          end
        end else begin
          tmo++;
          if (tmo > 200) begin
            n_tests++; n_fail++;
            $display("FAIL ack_wait: requester %0d waited %0d cycles", who,
                     tmo);
            req = 0;
            tmo = 0;
            set_req(who, 0);
          end
        end
      end else if (stop) begin
        break;
      end else if ($urandom_range(0, 9) < 3) begin
        rand_fields(who);
        req = 1;
        set_req(who, 1);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [8:0] rd;
    logic [2:0] dc;
    int order [4];
    int ackt [4];
    int exp_order [4];
    int na;
    int t;

`ifdef PSEVDO_RAM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif

    repeat (2) @(negedge CLKS);
    chk("rst_ack", 50'({ACKA, ACKB}), 50'd0);
    chk("rst_strobes", 50'({RAM_WRB, RAM_RDB}), 50'd3);
    chk("rst_dc", 50'(RAM_DC), 50'd0);
    chk("rst_rdata", 50'({RDATAA, RDATAB}), 50'd0);
    chk("rst_addr_din", 50'({RAM_WADDR, RAM_RADDR, RAM_DIN}), 50'd0);

    // Contention straight out of reset, both requesters held high.
    RSTB = 1'b1;
    set_fields(0, 1, 2'd0, 8'h40, 9'h011);
    set_fields(1, 1, 2'd1, 8'h41, 9'h122);
    REQA = 1; REQB = 1;
    na = 0;
    t = 0;
    while (na < 4 && t < 60) begin
      @(negedge CLKS);
      t++;
      if (ACKA || ACKB) begin
        order[na] = ACKB ? 1 : 0;
        ackt[na]  = t;
        if (ACKA) WDATAA = 9'($urandom_range(0, 511));
        if (ACKB) WDATAB = 9'($urandom_range(0, 511));
        na++;
        if (na == 4) begin
          REQA = 0; REQB = 0;
        end
      end
    end
    REQA = 0; REQB = 0;
    chk("contention_count", 50'(na), 50'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("grant_order_%0d", i), 50'(order[i]), 50'(exp_order[i]));
    for (int i = 1; i < 4; i++)
      chk($sformatf("b2b_spacing_%0d", i), 50'(ackt[i] - ackt[i-1]), 50'd3);

    // Single write then read, bank 2 (DO2 side).
    @(negedge CLKS);
    access(0, 1, 2'd2, 8'h15, 9'h1A5, lat, rd, dc);
    chk("wr_latency", 50'(lat), 50'd3);
    chk("wr_dc", 50'(dc), 50'd2);
    access(0, 0, 2'd2, 8'h15, 9'h000, lat, rd, dc);
    chk("rd_latency", 50'(lat), 50'd4);
    chk("rd_data_a", 50'(rd), 50'h1A5);

    // DO1/DO2 selection via requester B.
    access(1, 1, 2'd1, 8'hFF, 9'h0F0, lat, rd, dc);
    chk("b_wr1_dc", 50'(dc), 50'd1);
    access(1, 1, 2'd3, 8'hFF, 9'h10F, lat, rd, dc);
    chk("b_wr3_dc", 50'(dc), 50'd3);
    access(1, 0, 2'd1, 8'hFF, 9'h000, lat, rd, dc);
    chk("b_rd1_data", 50'(rd), 50'h0F0);
    chk("b_rd1_dc", 50'(dc), 50'd1);
    access(1, 0, 2'd3, 8'hFF, 9'h000, lat, rd, dc);
    chk("b_rd3_data", 50'(rd), 50'h10F);
    chk("b_rd3_dc", 50'(dc), 50'd3);

    // Reset asserted while a read sits in the capture cycle.
    @(negedge CLKS);
    set_fields(0, 0, 2'd2, 8'h15, 9'h000);
    REQA = 1;
    @(negedge CLKS);
    @(negedge CLKS);
    RSTB = 1'b0;
    REQA = 0;
    #1;
    chk("mid_rst_ack", 50'({ACKA, ACKB}), 50'd0);
    chk("mid_rst_strobes", 50'({RAM_WRB, RAM_RDB}), 50'd3);
    chk("mid_rst_rdata", 50'({RDATAA, RDATAB}), 50'd0);
    chk("mid_rst_dc", 50'(RAM_DC), 50'd0);
    chk("mid_rst_addr_din", 50'({RAM_WADDR, RAM_RADDR, RAM_DIN}), 50'd0);
    @(negedge CLKS);
    RSTB = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLKS);
      chk("post_rst_no_ack", 50'({ACKA, ACKB}), 50'd0);
      chk("post_rst_idle", 50'({RAM_WRB, RAM_RDB}), 50'd3);
    end

    // Random mixed traffic from both requesters.
    fork
      req_loop(0, 10000);
      req_loop(1, 10000);
    join
    repeat (6) @(negedge CLKS);
    chk("ack_total", 50'(dut_acks), 50'(model_acks));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psevdo_ram_arbiter.md
# psevdo_ram_arbiter

Single-clock controller that shares one `psevdo_ram_block` (four 256×9 banks, active-low `RDB`/`WRB` strobes, bank decode `DC_in2..0`, outputs `DO1` for banks 0/1 and `DO2` for banks 2/3) between two requesters, A and B. The block serialises accesses because the RAM has a single bank-select shared by its read and write ports. It arbitrates between the requesters, sequences the strobes, and captures the bank-correct read word. `RCLKS` and `WCLKS` of the RAM are both driven from `CLKS` at the level above.

## Interface
- No parameters; widths fixed by the RAM (9-bit data, 2-bit bank, 8-bit address).
- `CLKS` in 1 — single clock; also feeds `RCLKS`/`WCLKS` of the RAM.
- `RSTB` in 1 — reset, asynchronous, active-low.
- `REQA`, `REQB` in 1 — access request, level, held until the matching ACK.
- `WEA`, `WEB` in 1 — 1 = write, 0 = read; stable while REQ is high.
- `BANKA`, `BANKB` in 2 — target bank 0..3.
- `ADDRA`, `ADDRB` in 8 — word address.
- `WDATAA`, `WDATAB` in 9 — write data.
- `ACKA`, `ACKB` out 1 — one-cycle completion pulse.
- `RDATAA`, `RDATAB` out 9 — read data, valid in the ACK cycle, held until that requester's next read completes.
- `RAM_DIN` out 9, `RAM_WADDR` out 8, `RAM_RADDR` out 8 — to `DIn`/`WADDR`/`RADDR`.
- `RAM_WRB`, `RAM_RDB` out 1 — active-low strobes.
- `RAM_DC` out 3 — to `{DC_in2,DC_in1,DC_in0}`; bit 2 always 0.
- `RAM_DO1`, `RAM_DO2` in 9 — RAM read outputs.

## Operation
- **Registers:** state register IDLE/WR/RD/CAP/DONE; round-robin pointer `last` (0 = A served last); latched `owner`, `bank`, `addr`, `wdata`, `we`.
- **IDLE:**
  - Sample `REQA`/`REQB`.
  - If exactly one is high, grant that requester.
  - If both are high, grant the one not equal to `last`.
  - On grant, latch that requester's fields, set `owner`, update `last := owner`, and go to WR (`we`=1) or RD (`we`=0).
- **WR:** `RAM_WRB`=0 for this single cycle; the RAM writes at the closing edge. Next state: DONE.
- **RD:** `RAM_RDB`=0 for this single cycle; the RAM registers the word at the closing edge. Next state: CAP.
- **CAP:**
  - Register `RAM_DO1` if `bank[1]`=0, else `RAM_DO2`, into `RDATAA` or `RDATAB` according to `owner`.
  - Next state: DONE.
- **DONE:** assert ACK of `owner` for one cycle, then go to IDLE.
- **RAM-side outputs** are registered and held constant from the grant edge through DONE:
  - `RAM_DC` = {1'b0, bank}.
  - `RAM_WADDR` = `RAM_RADDR` = addr.
  - `RAM_DIN` = wdata.
- **Strobes:** at most one strobe low in any cycle; the two strobes are never low together.
- **Requester rule:** the requester deasserts REQ at the edge where it samples ACK high, or keeps it high with new fields for a back-to-back access. The arbiter does not sample REQ during WR/RD/CAP/DONE.
- **Reset (asynchronous, including mid-access):**
  - State goes to IDLE; `RAM_WRB`=`RAM_RDB`=1.
  - `ACKA`=`ACKB`=0.
  - `RDATAA`=`RDATAB`=0, `RAM_DC`=0, addresses and `RAM_DIN`=0.
  - `last`=1, so A wins the first contention.
  - An aborted access is lost and never ACKed.

## Timing
- Grant edge = edge *g* (IDLE with REQ high).
- **Write:** `RAM_WRB` low in cycle *g*..*g*+1; RAM write at edge *g*+1; ACK high in cycle *g*+2..*g*+3. Throughput: one write per 3 cycles.
- **Read:** `RAM_RDB` low *g*..*g*+1; RAM output at *g*+1; RDATA registered at *g*+2; ACK and RDATA valid *g*+3..*g*+4. Throughput: one read per 4 cycles.
- **Write then read of the same word** (either requester) returns the new data; the accesses are serialised.
- **Contention:** with both REQ held continuously, grants alternate A, B, A, B…

## Configuration
- `PSEVDO_RAM_ARB_FIXED_PRIO_EN`
  - **Defined:** A always wins contention. The `last` pointer is not implemented; B is served only when `REQA` is low in IDLE.
  - **Undefined:** round-robin as described under Operation.
- Single-requester timing is identical in both builds.

## Test plan
- **Reset:** assert `RSTB`=0 mid-read (state CAP).
  - All outputs go to their reset values immediately.
  - No ACK follows.
  - After release, an idle bus keeps `RAM_WRB`=`RAM_RDB`=1.
- **Single write then read:** A writes bank 2, addr 0x15, data 0x1A5, then reads it back.
  - Write ACK 2 cycles after grant.
  - Read `RDATAA`=0x1A5 sourced from `DO2`; read ACK 3 cycles after grant.
- **DO1/DO2 selection:** B writes 0x0F0 to bank 1 addr 0xFF and 0x10F to bank 3 addr 0xFF, then reads both.
  - `RDATAB`=0x0F0, then 0x10F.
  - `RAM_DC` = 3'b001, then 3'b011.
- **Contention:** both REQ held high for 4 accesses from reset.
  - Grant order A, B, A, B.
  - With the macro defined: A, A, A, A.
- **Strobe exclusivity:** random mixed traffic for 10k cycles.
  - Assert never (`RAM_WRB`==0 && `RAM_RDB`==0).
  - Every strobe pulse is exactly 1 cycle.
  - Exactly one ACK per grant.
- **Back-to-back:** A keeps REQ high and changes fields in its ACK cycle.
  - The next grant occurs at the first IDLE edge.
  - No request is dropped or duplicated.
